sakebi_rmii_rx: RTL and testbench



---
 rtl/sakebi_rmii_pkg.sv | 28 ++
 rtl/sakebi_sync_fifo.sv | 57 +++++
 rtl/sakebi_rmii_rx.sv | 178 +++++++++++++++++
 tb/tb_sakebi_rmii_rx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sakebi_rmii_pkg.sv
// Shared types and constants for the sakebi RMII receive front end.
package sakebi_rmii_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] DIBIT_PREAMBLE = 2'b01;
  localparam logic [1:0] DIBIT_SFD      = 2'b11;
  localparam logic [1:0] DIBIT_FALSE    = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2
  } rx_state_e;

  // Drop a dibit into its LSB-first slot of the byte under assembly.
  function automatic logic [BYTE_W-1:0] place_dibit(
    input logic [BYTE_W-1:0] asm_in,
    input logic [1:0]        idx,
    input logic [1:0]        dibit
  );
    logic [BYTE_W-1:0] r;
    r = asm_in;
    r[{idx, 1'b0} +: 2] = dibit;
    return r;
  endfunction

endpackage

// File: rtl/sakebi_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty flags.
// The head entry is read combinationally so it is visible the cycle after
// it is written; an empty FIFO presents all-zero data.
module sakebi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  // Flags, guarded push/pop and next pointer values.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    // A full FIFO still accepts a push when a pop frees the head slot.
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    dout     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/sakebi_rmii_rx.sv
// RMII receive front end: preamble/SFD strip, LSB-first dibit-to-byte
// assembly, and an AXI4-Stream master fed from a FWFT byte FIFO.
// Optional feature macro: SAKEBI_RMII_RX_TLAST_EN adds o_axis_TLAST by
// holding each completed byte until the next one (or the frame end) is known.
module sakebi_rmii_rx
  import sakebi_rmii_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       i_rmii_REF_CLK,
  input  logic       i_rmii_RST,
  input  logic       i_rmii_CRS_DV,
  input  logic [1:0] i_rmii_RXD,
  output logic       o_axis_TVALID,
  input  logic       i_axis_TREADY,
`ifdef SAKEBI_RMII_RX_TLAST_EN
  output logic       o_axis_TLAST,
`endif
  output logic [7:0] o_axis_TDATA
);

`ifdef SAKEBI_RMII_RX_TLAST_EN
  localparam int FIFO_W = BYTE_W + 1;
`else
  localparam int FIFO_W = BYTE_W;
`endif

  rx_state_e         state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [BYTE_W-1:0] asm_q, asm_d;
  logic              byte_done;
  logic [BYTE_W-1:0] byte_val;

  logic              fifo_push_req;
  logic              fifo_push;
  logic [FIFO_W-1:0] fifo_din;
  logic              fifo_pop;
  logic [FIFO_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;

`ifdef SAKEBI_RMII_RX_TLAST_EN
  logic              frame_end;
  logic [BYTE_W-1:0] pend_q, pend_d;
  logic              pend_valid_q, pend_valid_d;
`endif

  // Receive state machine: next state, dibit assembly and byte completion.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    asm_d     = asm_q;
    byte_done = 1'b0;
    byte_val  = '0;
`ifdef SAKEBI_RMII_RX_TLAST_EN
    frame_end = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (i_rmii_CRS_DV && (i_rmii_RXD == DIBIT_PREAMBLE)) begin
          state_d = PREAMBLE;
        end
      end
      PREAMBLE: begin
        if (!i_rmii_CRS_DV) begin
          state_d = IDLE;
        end else if (i_rmii_RXD == DIBIT_SFD) begin
          state_d = DATA;
          idx_d   = 2'd0;
        end else if (i_rmii_RXD == DIBIT_FALSE) begin
          state_d = IDLE;
        end
      end
      DATA: begin
        // At odd indices the PHY toggles CRS_DV at end of frame, so the
        // dibit is taken regardless; only a low at an even index ends it.
        if (i_rmii_CRS_DV || idx_q[0]) begin
          asm_d = place_dibit(asm_q, idx_q, i_rmii_RXD);
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            byte_done = 1'b1;
            byte_val  = asm_d;
          end
        end else begin
          state_d = IDLE;
          idx_d   = 2'd0;
`ifdef SAKEBI_RMII_RX_TLAST_EN
          frame_end = 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  // State, dibit index and assembly register.
  always_ff @(posedge i_rmii_REF_CLK or posedge i_rmii_RST) begin
    if (i_rmii_RST) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
    end
  end

`ifdef SAKEBI_RMII_RX_TLAST_EN
  // Hold the latest byte until we know whether it is the last of its frame.
  always_comb begin
    pend_d        = pend_q;
    pend_valid_d  = pend_valid_q;
    fifo_push_req = 1'b0;
    fifo_din      = '0;
    if (byte_done) begin
      if (pend_valid_q) begin
        fifo_push_req = 1'b1;
        fifo_din      = {1'b0, pend_q};
      end
      pend_d       = byte_val;
      pend_valid_d = 1'b1;
    end else if (frame_end) begin
      if (pend_valid_q) begin
        fifo_push_req = 1'b1;
        fifo_din      = {1'b1, pend_q};
      end
      pend_valid_d = 1'b0;
    end
  end

  // Pending-byte register.
  always_ff @(posedge i_rmii_REF_CLK or posedge i_rmii_RST) begin
    if (i_rmii_RST) begin
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end
`else
  // Completed bytes go straight into the FIFO on the edge that finishes them.
  always_comb begin
    fifo_push_req = byte_done;
    fifo_din      = byte_val;
  end
`endif

  // Stream handshake; a byte arriving while full with no pop is dropped here.
  always_comb begin
    fifo_pop      = !fifo_empty && i_axis_TREADY;
    fifo_push     = fifo_push_req && (!fifo_full || fifo_pop);
    o_axis_TVALID = !fifo_empty;
    o_axis_TDATA  = fifo_dout[BYTE_W-1:0];
`ifdef SAKEBI_RMII_RX_TLAST_EN
    o_axis_TLAST  = fifo_dout[BYTE_W];
`endif
  end

  sakebi_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_rmii_REF_CLK),
    .rst   (i_rmii_RST),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_sakebi_rmii_rx.sv
// Directed testbench for sakebi_rmii_rx. Inputs change on the falling edge
// and outputs are checked on the following falling edge.
module tb_sakebi_rmii_rx;

  logic       clk;
  logic       rst;
  logic       crs;
  logic [1:0] rxd;
  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;
`ifdef SAKEBI_RMII_RX_TLAST_EN
  logic       tlast;
`endif

  int vectors;
  int miscompares;
  logic [7:0] exp_q[$];

  sakebi_rmii_rx #(
    .FIFO_DEPTH (16)
  ) dut (
    .i_rmii_REF_CLK (clk),
    .i_rmii_RST     (rst),
    .i_rmii_CRS_DV  (crs),
    .i_rmii_RXD     (rxd),
    .o_axis_TVALID  (tvalid),
    .i_axis_TREADY  (tready),
`ifdef SAKEBI_RMII_RX_TLAST_EN
    .o_axis_TLAST   (tlast),
`endif
    .o_axis_TDATA   (tdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one dibit at a falling edge; return on the next falling edge.
  task automatic step(input logic c, input logic [1:0] d);
    crs = c;
    rxd = d;
    @(negedge clk);
  endtask

  task automatic preamble();
    for (int i = 0; i < 5; i++) step(1'b1, 2'b00);
    for (int i = 0; i < 10; i++) step(1'b1, 2'b01);
    step(1'b1, 2'b11);
  endtask

  task automatic send_byte(input logic [7:0] b);
    step(1'b1, b[1:0]);
    step(1'b1, b[3:2]);
    step(1'b1, b[5:4]);
    step(1'b1, b[7:6]);
  endtask

  // Pop every expected byte in order, then require the stream to be empty.
  task automatic drain();
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk("drain_valid", {8'h00, tvalid}, 9'h001);
      chk("drain_data", {1'b0, tdata}, {1'b0, exp_q[i]});
      tready = 1'b1;
      step(1'b0, 2'b00);
      tready = 1'b0;
    end
    chk("drain_empty", {8'h00, tvalid}, 9'h000);
    exp_q.delete();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst    = 1'b1;
    crs    = 1'b0;
    rxd    = 2'b00;
    tready = 1'b0;
    @(negedge clk);
    chk("reset_tvalid", {8'h00, tvalid}, 9'h000);
    chk("reset_tdata", {1'b0, tdata}, 9'h000);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 2'b00);

`ifdef SAKEBI_RMII_RX_TLAST_EN
    // Two-byte frame: first byte waits in the pending register.
    preamble();
    send_byte(8'h11);
    chk("tl_pending", {8'h00, tvalid}, 9'h000);
    send_byte(8'h22);
    chk("tl_first_valid", {8'h00, tvalid}, 9'h001);
    chk("tl_first_data", {1'b0, tdata}, 9'h011);
    chk("tl_first_last", {8'h00, tlast}, 9'h000);
    step(1'b0, 2'b00);
    chk("tl_hold_data", {1'b0, tdata}, 9'h011);
    tready = 1'b1;
    step(1'b0, 2'b00);
    tready = 1'b0;
    chk("tl_second_valid", {8'h00, tvalid}, 9'h001);
    chk("tl_second_data", {1'b0, tdata}, 9'h022);
    chk("tl_second_last", {8'h00, tlast}, 9'h001);
    tready = 1'b1;
    step(1'b0, 2'b00);
    tready = 1'b0;
    chk("tl_empty", {8'h00, tvalid}, 9'h000);
`else
    // Single byte 0x9E; TVALID rises right after the 4th dibit.
    preamble();
    step(1'b1, 2'b10);
    step(1'b1, 2'b11);
    step(1'b1, 2'b01);
    chk("t1_not_yet", {8'h00, tvalid}, 9'h000);
    chk("t1_empty_data", {1'b0, tdata}, 9'h000);
    step(1'b1, 2'b10);
    chk("t1_valid", {8'h00, tvalid}, 9'h001);
    chk("t1_data", {1'b0, tdata}, 9'h09E);
    step(1'b0, 2'b00);
    exp_q = '{8'h9E};
    drain();

    // Two bytes with TREADY high: each popped on the edge after it appears.
    tready = 1'b1;
    preamble();
    step(1'b1, 2'b10);
    step(1'b1, 2'b11);
    step(1'b1, 2'b01);
    step(1'b1, 2'b10);
    chk("t2_b0_valid", {8'h00, tvalid}, 9'h001);
    chk("t2_b0_data", {1'b0, tdata}, 9'h09E);
    step(1'b1, 2'b01);
    chk("t2_b0_popped", {8'h00, tvalid}, 9'h000);
    step(1'b1, 2'b10);
    step(1'b1, 2'b11);
    step(1'b1, 2'b01);
    chk("t2_b1_valid", {8'h00, tvalid}, 9'h001);
    chk("t2_b1_data", {1'b0, tdata}, 9'h079);
    step(1'b0, 2'b00);
    chk("t2_b1_popped", {8'h00, tvalid}, 9'h000);
    tready = 1'b0;

    // Overflow: 20 distinct bytes into 16 entries, head held throughout.
    preamble();
    for (int k = 0; k < 20; k++) begin
      send_byte(8'h10 + 8'(k));
      if (k == 7) chk("t3_head_mid", {1'b0, tdata}, 9'h010);
    end
    step(1'b0, 2'b00);
    chk("t3_head_end", {1'b0, tdata}, 9'h010);
    for (int k = 0; k < 16; k++) exp_q.push_back(8'h10 + 8'(k));
    drain();

    // CRS_DV toggling at end of frame: odd-index dibits survive.
    preamble();
    send_byte(8'hA5);
    send_byte(8'h3C);
    step(1'b1, 2'b01);
    step(1'b0, 2'b10);
    step(1'b1, 2'b11);
    step(1'b0, 2'b00);
    step(1'b1, 2'b10);
    step(1'b0, 2'b11);
    step(1'b0, 2'b01);
    step(1'b1, 2'b11);
    step(1'b1, 2'b00);
    step(1'b0, 2'b00);
    exp_q = '{8'hA5, 8'h3C, 8'h39};
    drain();

    // False carrier, trailing junk, then a clean frame.
    for (int i = 0; i < 4; i++) step(1'b1, 2'b01);
    step(1'b1, 2'b10);
    step(1'b1, 2'b11);
    send_byte(8'h9E);
    step(1'b0, 2'b00);
    step(1'b0, 2'b00);
    chk("t5_no_bytes", {8'h00, tvalid}, 9'h000);
    preamble();
    send_byte(8'h5A);
    step(1'b0, 2'b00);
    exp_q = '{8'h5A};
    drain();

    // Reset pulse mid-byte clears the FIFO at once; rest of frame ignored.
    preamble();
    send_byte(8'hC3);
    chk("t6_pre_valid", {8'h00, tvalid}, 9'h001);
    chk("t6_pre_data", {1'b0, tdata}, 9'h0C3);
    step(1'b1, 2'b10);
    step(1'b1, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", {8'h00, tvalid}, 9'h000);
    chk("t6_rst_data", {1'b0, tdata}, 9'h000);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 2'b10);
    step(1'b1, 2'b11);
    send_byte(8'hE2);
    step(1'b0, 2'b00);
    chk("t6_after_rst", {8'h00, tvalid}, 9'h000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
